// File: rtl/maxnet_datapath_if.sv
// rtl/maxnet_datapath_if.sv - controller/datapath strobe and result bundle for the maxnet engine
interface maxnet_datapath_if #(
  parameter int WIDTH = 8
);
  logic                 read;
  logic                 load_y;
  logic                 select_y;
  logic                 mult;
  logic                 sum;
  logic                 done;
  logic [4*WIDTH-1:0]   x_in;
  logic                 s;
  logic [4*WIDTH-1:0]   y_out;
  logic [1:0]           winner_idx;
  logic                 winner_valid;

  modport master (
    output read, load_y, select_y, mult, sum, done, x_in,
    input  s, y_out, winner_idx, winner_valid
  );

  modport slave (
    input  read, load_y, select_y, mult, sum, done, x_in,
    output s, y_out, winner_idx, winner_valid
  );
endinterface

// File: rtl/maxnet_datapath.sv
// rtl/maxnet_datapath.sv - 4-lane winner-take-all iteration datapath driven by controller strobes
module maxnet_datapath #(
  parameter int WIDTH     = 8,
  parameter int EPS_SHIFT = 3,
  parameter int MAX_ITER  = 15
) (
  input logic               clock,
  input logic               reset,
  maxnet_datapath_if.slave  bus
);

  typedef logic signed [WIDTH+1:0] wide_t;
  localparam logic [7:0] ITER_MAX = 8'(MAX_ITER);

  logic [3:0][WIDTH-1:0] x_reg;
  logic [3:0][WIDTH-1:0] y_reg;
  wide_t [3:0]           p_reg;
  logic [3:0][WIDTH-1:0] new_reg;
  logic [7:0]            iter_cnt;
  logic [1:0]            winner_idx;
  logic                  winner_valid;

  logic [3:0][WIDTH-1:0] x_clamped;
  wide_t                 total;
  wide_t                 others [4];
  wide_t [3:0]           p_next;
  wide_t                 diff [4];
  logic [3:0][WIDTH-1:0] new_next;
  logic [1:0]            best_idx;
  logic [WIDTH-1:0]      best_val;
  logic [2:0]            nz_cnt;

  always_comb begin
    total = '0;
    for (int i = 0; i < 4; i++) begin
      total = total + $signed({2'b00, y_reg[i]});
    end
    for (int i = 0; i < 4; i++) begin
      x_clamped[i] = bus.x_in[i*WIDTH + WIDTH - 1] ? '0 : bus.x_in[i*WIDTH +: WIDTH];
      others[i]    = total - $signed({2'b00, y_reg[i]});
      p_next[i]    = others[i] >>> EPS_SHIFT;
      diff[i]      = $signed({2'b00, y_reg[i]}) - $signed(p_reg[i]);
      // Negative results clamp to zero; the positive-overflow saturation is unreachable for legal activations
      if (diff[i][WIDTH+1]) begin
        new_next[i] = '0;
      end else if (diff[i][WIDTH]) begin
        new_next[i] = '1;
      end else begin
        new_next[i] = diff[i][WIDTH-1:0];
      end
    end
  end

  // Strict greater-than while scanning upward keeps ties on the lowest index
  always_comb begin
    best_idx = 2'd0;
    best_val = y_reg[0];
    for (int i = 1; i < 4; i++) begin
      if (y_reg[i] > best_val) begin
        best_idx = 2'(i);
        best_val = y_reg[i];
      end
    end
  end

  always_comb begin
    nz_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      nz_cnt = nz_cnt + {2'b00, |new_reg[i]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_reg        <= '0;
      y_reg        <= '0;
      p_reg        <= '0;
      new_reg      <= '0;
      iter_cnt     <= '0;
      winner_idx   <= '0;
      winner_valid <= 1'b0;
    end else if (bus.read) begin
      x_reg        <= x_clamped;
      iter_cnt     <= '0;
      winner_valid <= 1'b0;
    end else if (bus.load_y) begin
      y_reg <= bus.select_y ? new_reg : x_reg;
    end else if (bus.mult) begin
      p_reg <= p_next;
    end else if (bus.sum) begin
      new_reg <= new_next;
      if (iter_cnt != ITER_MAX) begin
        iter_cnt <= iter_cnt + 8'd1;
      end
    end else if (bus.done) begin
      winner_idx   <= best_idx;
      winner_valid <= |y_reg;
    end
  end

  // Stop once at most one lane survives or the iteration cap is hit
  assign bus.s            = (nz_cnt <= 3'd1) || (iter_cnt == ITER_MAX);
  assign bus.y_out        = y_reg;
  assign bus.winner_idx   = winner_idx;
  assign bus.winner_valid = winner_valid;

endmodule

// File: tb/tb_maxnet_datapath.sv
// tb/tb_maxnet_datapath.sv - directed-vector bench for maxnet_datapath
module tb_maxnet_datapath;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  int   iters;
  logic stop;

  maxnet_datapath_if #(.WIDTH(8)) bus ();

  maxnet_datapath #(
    .WIDTH     (8),
    .EPS_SHIFT (3),
    .MAX_ITER  (15)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic r, input logic ly, input logic sel,
                       input logic m, input logic su, input logic d);
    @(negedge clock);
    bus.read     = r;
    bus.load_y   = ly;
    bus.select_y = sel;
    bus.mult     = m;
    bus.sum      = su;
    bus.done     = d;
    @(posedge clock);
    #1;
    bus.read     = 1'b0;
    bus.load_y   = 1'b0;
    bus.select_y = 1'b0;
    bus.mult     = 1'b0;
    bus.sum      = 1'b0;
    bus.done     = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] x);
    bus.x_in = x;
    pulse(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b0;
    bus.read     = 1'b0;
    bus.load_y   = 1'b0;
    bus.select_y = 1'b0;
    bus.mult     = 1'b0;
    bus.sum      = 1'b0;
    bus.done     = 1'b0;
    bus.x_in     = '0;
    #2;
    check("rst_y_out", 64'(bus.y_out), 64'h0);
    check("rst_s", 64'(bus.s), 64'h1);
    check("rst_winner_valid", 64'(bus.winner_valid), 64'h0);
    check("rst_winner_idx", 64'(bus.winner_idx), 64'h0);
    #10;
    reset = 1'b1;

    // Basic iteration: {10,20,30,40} converges to lane0 = 25 after 8 iterations
    do_read(32'h0A14_1E28);
    pulse(0, 1, 0, 0, 0, 0);
    check("t1_y_load", 64'(bus.y_out), 64'h0A14_1E28);
    iters = 0;
    stop  = 1'b0;
    while (!stop && iters < 20) begin
      pulse(0, 0, 0, 1, 0, 0);
      pulse(0, 0, 0, 0, 1, 0);
      iters++;
      if (iters == 1) begin
        check("t1_p_reg", 64'(dut.p_reg), 64'({10'd11, 10'd10, 10'd8, 10'd7}));
        check("t1_new_reg", 64'(dut.new_reg), 64'h000A_1621);
        check("t1_s_first", 64'(bus.s), 64'h0);
      end
      stop = bus.s;
      pulse(0, 1, 1, 0, 0, 0);
    end
    check("t1_iters", 64'(iters), 64'd8);
    check("t1_y_final", 64'(bus.y_out), 64'h0000_0019);
    pulse(0, 0, 0, 0, 0, 1);
    check("t1_winner_idx", 64'(bus.winner_idx), 64'd0);
    check("t1_winner_valid", 64'(bus.winner_valid), 64'd1);

    // Single survivor in lane 2
    do_read(32'h0032_0000);
    check("t2_valid_cleared", 64'(bus.winner_valid), 64'd0);
    pulse(0, 1, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 0);
    pulse(0, 0, 0, 0, 1, 0);
    check("t2_new_reg", 64'(dut.new_reg), 64'h0032_0000);
    check("t2_s", 64'(bus.s), 64'h1);
    pulse(0, 1, 1, 0, 0, 0);
    pulse(0, 0, 0, 0, 0, 1);
    check("t2_y_out", 64'(bus.y_out), 64'h0032_0000);
    check("t2_winner_idx", 64'(bus.winner_idx), 64'd2);
    check("t2_winner_valid", 64'(bus.winner_valid), 64'd1);

    // Tie between lanes 0/1: decays to 7 and stops only on the iteration cap
    do_read(32'h0000_1414);
    pulse(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      pulse(0, 0, 0, 1, 0, 0);
      pulse(0, 0, 0, 0, 1, 0);
      if (i == 1)  check("t3_new_it1", 64'(dut.new_reg), 64'h0000_1212);
      if (i == 2)  check("t3_new_it2", 64'(dut.new_reg), 64'h0000_1010);
      if (i == 10) check("t3_new_it10", 64'(dut.new_reg), 64'h0000_0707);
      if (i == 14) check("t3_s_it14", 64'(bus.s), 64'h0);
      if (i == 15) check("t3_s_it15", 64'(bus.s), 64'h1);
      pulse(0, 1, 1, 0, 0, 0);
    end
    check("t3_iter_cnt", 64'(dut.iter_cnt), 64'd15);
    pulse(0, 0, 0, 1, 0, 0);
    pulse(0, 0, 0, 0, 1, 0);
    check("t3_iter_sat", 64'(dut.iter_cnt), 64'd15);
    pulse(0, 0, 0, 0, 0, 1);
    check("t3_y_out", 64'(bus.y_out), 64'h0000_0707);
    check("t3_winner_idx", 64'(bus.winner_idx), 64'd0);
    check("t3_winner_valid", 64'(bus.winner_valid), 64'd1);

    // Negative inputs clamp; everything collapses to zero
    do_read(32'h8000_FF00);
    check("t4_x_reg", 64'(dut.x_reg), 64'h0);
    check("t4_iter_cleared", 64'(dut.iter_cnt), 64'd0);
    pulse(0, 1, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 0);
    pulse(0, 0, 0, 0, 1, 0);
    check("t4_s", 64'(bus.s), 64'h1);
    pulse(0, 1, 1, 0, 0, 0);
    pulse(0, 0, 0, 0, 0, 1);
    check("t4_winner_valid", 64'(bus.winner_valid), 64'd0);
    check("t4_winner_idx", 64'(bus.winner_idx), 64'd0);

    // Async reset between mult and sum
    do_read(32'h0A14_1E28);
    pulse(0, 1, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 0);
    check("t5_p_before", 64'(dut.p_reg), 64'({10'd11, 10'd10, 10'd8, 10'd7}));
    reset = 1'b0;
    #1;
    check("t5_y_out", 64'(bus.y_out), 64'h0);
    check("t5_p_reg", 64'(dut.p_reg), 64'h0);
    check("t5_x_reg", 64'(dut.x_reg), 64'h0);
    check("t5_s", 64'(bus.s), 64'h1);
    reset = 1'b1;
    pulse(0, 0, 0, 0, 1, 0);
    check("t5_new_after", 64'(dut.new_reg), 64'h0);
    check("t5_s_after", 64'(bus.s), 64'h1);

    // read wins over sum in the same cycle
    do_read(32'h0A14_1E28);
    pulse(0, 1, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 0);
    pulse(0, 0, 0, 0, 1, 0);
    check("t6_iter_pre", 64'(dut.iter_cnt), 64'd1);
    bus.x_in = 32'h0102_0304;
    pulse(1, 0, 0, 0, 1, 0);
    check("t6_x_reg", 64'(dut.x_reg), 64'h0102_0304);
    check("t6_iter_cnt", 64'(dut.iter_cnt), 64'd0);
    check("t6_new_reg", 64'(dut.new_reg), 64'h000A_1621);
    check("t6_s", 64'(bus.s), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
